// File: rtl/bus_datapath.sv
// Single-bus 32-bit datapath core: bus multiplexer, general/special register set and a
// combinational ALU whose 64-bit result feeds the ZHIGH/ZLO pair.
module bus_datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  bus_sel,
   input  logic [15:0] r_in,
   input  logic        hi_in,
   input  logic        lo_in,
   input  logic        pc_in,
   input  logic        mar_in,
   input  logic        ir_in,
   input  logic        y_in,
   input  logic        zhigh_in,
   input  logic        zlo_in,
   input  logic [31:0] mdr_q,
   input  logic [31:0] inport_q,
   input  logic [31:0] c_sign_extended,
   input  logic [3:0]  control,
   input  logic        inc_pc,
   output logic [31:0] bus,
   output logic [31:0] ir_q,
   output logic [31:0] mar_q,
   output logic [31:0] pc_q
);

   logic [31:0]        r_q [16];
   logic [31:0]        hi_q, lo_q, zhigh_q, zlo_q, y_q;
   logic [31:0]        zhigh_d, zlo_d;
   logic [4:0]         shamt;
   logic signed [63:0] product;
   logic [31:0]        ror_v, rol_v;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin : bus_mux
      bus = 32'h0;
      if (!bus_sel[4]) begin
         bus = r_q[bus_sel[3:0]];
      end else begin
         case (bus_sel)
            5'd16:   bus = hi_q;
            5'd17:   bus = lo_q;
            5'd18:   bus = zhigh_q;
            5'd19:   bus = zlo_q;
            5'd20:   bus = pc_q;
            5'd21:   bus = mdr_q;
            5'd22:   bus = inport_q;
            5'd23:   bus = c_sign_extended;
            default: bus = 32'h0;
         endcase
      end
   end

   assign shamt   = bus[4:0];
   assign product = $signed(y_q) * $signed(bus);
   // A shift by 32 yields zero, so the complementary half vanishes when shamt is 0.
   assign ror_v   = (y_q >> shamt) | (y_q << (6'd32 - {1'b0, shamt}));
   assign rol_v   = (y_q << shamt) | (y_q >> (6'd32 - {1'b0, shamt}));

   always_comb begin : alu
      zhigh_d = 32'h0;
      zlo_d   = 32'h0;
      if (inc_pc) begin
         zlo_d = bus + 32'd1;
      end else begin
         case (control)
            4'd0:  zlo_d = y_q + bus;
            4'd1:  begin
               zhigh_d = product[63:32];
               zlo_d   = product[31:0];
            end
            4'd2:  zlo_d = y_q - bus;
            4'd3:  zlo_d = y_q & bus;
            4'd4:  zlo_d = y_q | bus;
            4'd5:  zlo_d = y_q >> shamt;
            4'd6:  zlo_d = y_q << shamt;
            4'd7:  zlo_d = $unsigned($signed(y_q) >>> shamt);
            4'd8:  zlo_d = ror_v;
            4'd9:  zlo_d = rol_v;
            4'd10: zlo_d = 32'h0 - bus;
            4'd11: zlo_d = ~bus;
            4'd12: begin
               if (bus == 32'h0) begin
                  zlo_d   = 32'hFFFF_FFFF;
                  zhigh_d = y_q;
               end else if (y_q == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
                  // Most-negative / -1 overflows: quotient wraps to itself, remainder 0.
                  zlo_d = y_q;
               end else begin
                  zlo_d   = $unsigned($signed(y_q) / $signed(bus));
                  zhigh_d = $unsigned($signed(y_q) % $signed(bus));
               end
            end
            default: ;
         endcase
      end
   end

   // Loading a register that is also driving the bus captures the pre-edge bus value.
   // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the register array is reset explicitly because the datapath must read 0 after reset.
         for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
         hi_q    <= 32'h0;
         lo_q    <= 32'h0;
         zhigh_q <= 32'h0;
         zlo_q   <= 32'h0;
         y_q     <= 32'h0;
         pc_q    <= 32'h0;
         mar_q   <= 32'h0;
         ir_q    <= 32'h0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (r_in[i]) r_q[i] <= bus;
         end
         if (hi_in)    hi_q    <= bus;
         if (lo_in)    lo_q    <= bus;
         if (zhigh_in) zhigh_q <= zhigh_d;
         if (zlo_in)   zlo_q   <= zlo_d;
         if (y_in)     y_q     <= bus;
         if (pc_in)    pc_q    <= bus;
         if (mar_in)   mar_q   <= bus;
         if (ir_in)    ir_q    <= bus;
      end
   end

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: stimulus pushes expected values from a bus-code
// indexed reference model; a negedge monitor pops and compares against DUT outputs.
module tb_bus_datapath;

   logic        clk;
   logic        reset;
   logic [4:0]  bus_sel;
   logic [15:0] r_in;
   logic        hi_in, lo_in, pc_in, mar_in, ir_in, y_in, zhigh_in, zlo_in;
   logic [31:0] mdr_q, inport_q, c_sign_extended;
   logic [3:0]  control;
   logic        inc_pc;
   logic [31:0] bus, ir_q, mar_q, pc_q;

   bus_datapath dut (
      .clk(clk), .reset(reset), .bus_sel(bus_sel), .r_in(r_in),
      .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .mar_in(mar_in),
      .ir_in(ir_in), .y_in(y_in), .zhigh_in(zhigh_in), .zlo_in(zlo_in),
      .mdr_q(mdr_q), .inport_q(inport_q), .c_sign_extended(c_sign_extended),
      .control(control), .inc_pc(inc_pc),
      .bus(bus), .ir_q(ir_q), .mar_q(mar_q), .pc_q(pc_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference state: m_reg is indexed by the bus code that reads it (0-15 Rn, 16 HI, 17 LO,
   // 18 ZHIGH, 19 ZLO, 20 PC).
   logic [31:0] m_reg [21];
   logic [31:0] m_ir, m_mar, m_y;

   typedef struct {
      string       name;
      int          kind;   // 0 bus, 1 ir_q, 2 mar_q, 3 pc_q
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   logic chk_valid;
   int   vectors;
   int   miscompares;

   function automatic logic [31:0] ref_bus(logic [4:0] sel);
      if (sel <= 5'd20) return m_reg[sel];
      if (sel == 5'd21) return mdr_q;
      if (sel == 5'd22) return inport_q;
      if (sel == 5'd23) return c_sign_extended;
      return 32'h0;
   endfunction

   function automatic logic [63:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic inc);
      longint      sa, sb, q, r, p;
      int          s;
      logic [31:0] lo;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = int'(b[4:0]);
      if (inc) return {32'h0, b + 32'd1};
      case (op)
         4'd0:  return {32'h0, a + b};
         4'd1:  begin p = sa * sb; return p; end
         4'd2:  return {32'h0, a - b};
         4'd3:  return {32'h0, a & b};
         4'd4:  return {32'h0, a | b};
         4'd5:  return {32'h0, a >> s};
         4'd6:  return {32'h0, a << s};
         4'd7:  begin p = sa >>> s; return {32'h0, p[31:0]}; end
         4'd8:  begin lo = a; repeat (s) lo = {lo[0], lo[31:1]}; return {32'h0, lo}; end
         4'd9:  begin lo = a; repeat (s) lo = {lo[30:0], lo[31]}; return {32'h0, lo}; end
         4'd10: return {32'h0, 32'h0 - b};
         4'd11: return {32'h0, ~b};
         4'd12: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: return 64'h0;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 21; i++) m_reg[i] = 32'h0;
      m_ir = 32'h0; m_mar = 32'h0; m_y = 32'h0;
   endtask

   task automatic clear_ctrl();
      r_in = 16'h0;
      hi_in = 0; lo_in = 0; pc_in = 0; mar_in = 0; ir_in = 0; y_in = 0;
      zhigh_in = 0; zlo_in = 0; inc_pc = 0;
   endtask

   task automatic all_enables();
      r_in = 16'hFFFF;
      hi_in = 1; lo_in = 1; pc_in = 1; mar_in = 1; ir_in = 1; y_in = 1;
      zhigh_in = 1; zlo_in = 1;
   endtask

   // One clock edge with the currently driven inputs; the model advances alongside.
   task automatic step();
      logic [31:0] b;
      logic [63:0] z;
      b = ref_bus(bus_sel);
      z = ref_alu(m_y, b, control, inc_pc);
      @(posedge clk);
      #1;
      if (reset) begin
         for (int i = 0; i < 16; i++) if (r_in[i]) m_reg[i] = b;
         if (hi_in)    m_reg[16] = b;
         if (lo_in)    m_reg[17] = b;
         if (zhigh_in) m_reg[18] = z[63:32];
         if (zlo_in)   m_reg[19] = z[31:0];
         if (pc_in)    m_reg[20] = b;
         if (mar_in)   m_mar = b;
         if (ir_in)    m_ir = b;
         if (y_in)     m_y = b;
      end
      clear_ctrl();
   endtask

   task automatic check_cycle(string name, int kind, logic [31:0] exp);
      exp_t e;
      e.name = name; e.kind = kind; e.exp = exp;
      sb_q.push_back(e);
      chk_valid = 1'b1;
      @(posedge clk);
      #1;
      chk_valid = 1'b0;
   endtask

   task automatic check_bus(logic [4:0] sel, string name);
      clear_ctrl();
      bus_sel = sel;
      check_cycle(name, 0, ref_bus(sel));
   endtask

   task automatic check_ir(string name);  clear_ctrl(); check_cycle(name, 1, m_ir);      endtask
   task automatic check_mar(string name); clear_ctrl(); check_cycle(name, 2, m_mar);     endtask
   task automatic check_pc(string name);  clear_ctrl(); check_cycle(name, 3, m_reg[20]); endtask

   // Y <- a (from MDR), then Z <- Y op b with b taken from bus code src.
   task automatic alu_op(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [4:0] src, string name);
      mdr_q = a; bus_sel = 5'd21; y_in = 1; step();
      mdr_q = b; c_sign_extended = b; inport_q = b; bus_sel = src;
      control = op; zhigh_in = 1; zlo_in = 1; step();
      check_bus(5'd19, {name, "_zlo"});
      check_bus(5'd18, {name, "_zhigh"});
   endtask

   task automatic mul_flow(logic [31:0] a, logic [31:0] b, string name);
      mdr_q = a; bus_sel = 5'd21; r_in = 16'h0004; step();
      mdr_q = b; r_in = 16'h0010; step();
      bus_sel = 5'd2; y_in = 1; step();
      bus_sel = 5'd4; control = 4'd1; zhigh_in = 1; zlo_in = 1; step();
      bus_sel = 5'd19; lo_in = 1; step();
      bus_sel = 5'd18; hi_in = 1; step();
      check_bus(5'd17, {name, "_lo"});
      check_bus(5'd16, {name, "_hi"});
   endtask

   task automatic pc_inc_flow(logic [31:0] start, string name);
      mdr_q = start; bus_sel = 5'd21; pc_in = 1; step();
      bus_sel = 5'd20; mar_in = 1; inc_pc = 1; zlo_in = 1; step();
      bus_sel = 5'd19; pc_in = 1; step();
      check_mar({name, "_mar"});
      check_pc({name, "_pc"});
   endtask

   // Monitor: compares whenever the stimulus presents a check cycle.
   exp_t        mon_e;
   logic [31:0] mon_act;
   always @(negedge clk) begin
      if (chk_valid) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: monitor had no expected value");
         end else begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
               1:       mon_act = ir_q;
               2:       mon_act = mar_q;
               3:       mon_act = pc_q;
               default: mon_act = bus;
            endcase
            if (mon_act !== mon_e.exp) begin
               miscompares++;
               $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] sel;
      vectors = 0; miscompares = 0; chk_valid = 1'b0;
      clear_ctrl();
      control = 4'd0; inport_q = 32'h0; c_sign_extended = 32'h0;
      model_clear();

      // Reset with every enable high and MDR on the bus.
      reset = 1'b1; bus_sel = 5'd21; mdr_q = 32'hDEADBEEF; all_enables();
      #2 reset = 1'b0;
      model_clear();
      all_enables(); step();
      all_enables(); step();
      for (int i = 0; i <= 20; i += 4) check_bus(5'(i), $sformatf("rst_hold_sel%0d", i));
      check_bus(5'd17, "rst_hold_lo");
      check_bus(5'd18, "rst_hold_zhigh");
      check_bus(5'd19, "rst_hold_zlo");
      check_ir("rst_hold_ir"); check_mar("rst_hold_mar"); check_pc("rst_hold_pc");

      reset = 1'b1; bus_sel = 5'd21; mdr_q = 32'hDEADBEEF; control = 4'd0; all_enables();
      step();
      for (int i = 0; i <= 20; i++) check_bus(5'(i), $sformatf("rst_rel_sel%0d", i));
      check_ir("rst_rel_ir"); check_mar("rst_rel_mar"); check_pc("rst_rel_pc");

      // Register load and bus select.
      mdr_q = 32'd54; bus_sel = 5'd21; r_in = 16'h0004; step();
      mdr_q = 32'd91; r_in = 16'h0010; step();
      check_bus(5'd2, "load_r2");
      check_bus(5'd4, "load_r4");
      check_bus(5'd30, "sel30_zero");

      mul_flow(32'd54, 32'd91, "mul_pos");
      mul_flow(32'hFFFF_FFFE, 32'd3, "mul_neg");

      pc_inc_flow(32'h0, "pc_inc0");
      pc_inc_flow(32'hFFFF_FFFF, "pc_wrap");

      alu_op(32'h8000_0001, 32'd4, 4'd5, 5'd21, "shr");
      alu_op(32'h8000_0001, 32'd4, 4'd7, 5'd23, "shra");
      alu_op(32'h8000_0001, 32'd4, 4'd8, 5'd22, "ror");
      alu_op(32'h8000_0001, 32'd4, 4'd2, 5'd21, "sub");
      alu_op(32'h8000_0001, 32'd4, 4'd9, 5'd21, "rol");
      alu_op(32'hFFFF_FFF9, 32'd2, 4'd12, 5'd21, "div");
      alu_op(32'hFFFF_FFF9, 32'd0, 4'd12, 5'd21, "div0");
      alu_op(32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 5'd21, "div_ovf");
      alu_op(32'h1234_5678, 32'h0, 4'd8, 5'd21, "ror0");

      // Same-cycle read and write of one register.
      mdr_q = 32'h0000_0010; bus_sel = 5'd21; r_in = 16'h0080; step();
      bus_sel = 5'd7; r_in = 16'h0080; y_in = 1; ir_in = 1; step();
      check_bus(5'd7, "self_load_r7");
      check_ir("self_load_ir");

      // Reset asserted mid-cycle aborts a pending Z load and clears Z.
      alu_op(32'd5, 32'd6, 4'd0, 5'd21, "pre_abort_add");
      mdr_q = 32'd100; bus_sel = 5'd21; zlo_in = 1; zhigh_in = 1; control = 4'd1; pc_in = 1;
      #2 reset = 1'b0;
      model_clear();
      step();
      reset = 1'b1;
      check_bus(5'd19, "abort_zlo");
      check_bus(5'd20, "abort_pc");

      // Randomized traffic.
      for (int i = 0; i < 160; i++) begin
         mdr_q = $urandom; inport_q = $urandom; c_sign_extended = $urandom;
         bus_sel = 5'($urandom_range(0, 31));
         control = 4'($urandom_range(0, 15));
         inc_pc = ($urandom_range(0, 9) == 0);
         r_in = 16'($urandom & $urandom);
         hi_in = ($urandom_range(0, 3) == 0); lo_in = ($urandom_range(0, 3) == 0);
         pc_in = ($urandom_range(0, 3) == 0); mar_in = ($urandom_range(0, 3) == 0);
         ir_in = ($urandom_range(0, 3) == 0); y_in = ($urandom_range(0, 2) == 0);
         zhigh_in = ($urandom_range(0, 1) == 0); zlo_in = ($urandom_range(0, 1) == 0);
         step();
         sel = 5'($urandom_range(0, 24));
         check_bus(sel, $sformatf("rand%0d_sel%0d", i, sel));
         case (i % 3)
            0:       check_ir($sformatf("rand%0d_ir", i));
            1:       check_mar($sformatf("rand%0d_mar", i));
            default: check_pc($sformatf("rand%0d_pc", i));
         endcase
      end

      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: %0d entries left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
